// File: rtl/io_spi_engine_pkg.sv
// Shared types and constants for the host-programmable SPI master engine.
package io_spi_engine_pkg;

    localparam int unsigned BUS_W  = 16;
    localparam int unsigned CTRL_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LEAD,
        ST_SHIFT_TRAIL,
        ST_HOLD
    } spi_state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL field layout, LSB last: [3:0] nbits-1, [4] cpol, [5] cpha, [6] lsb_first, [9:7] ch, [10] irq_en
    typedef struct packed {
        logic       irq_en;
        logic [2:0] ch;
        logic       lsb_first;
        logic       cpha;
        logic       cpol;
        logic [3:0] nbits_m1;
    } spi_ctrl_t;

    // Word bit position carrying serial bit k of the transfer
    function automatic logic [3:0] bit_index(input logic [3:0] nbits_m1,
                                             input logic       lsb_first,
                                             input logic [3:0] k);
        return lsb_first ? k : 4'(nbits_m1 - k);
    endfunction

endpackage

// File: rtl/io_spi_clkgen.sv
// Half-period timer: o_tick_c pulses on the last clk of each (i_div+1)-clk phase.
module io_spi_clkgen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick_c
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick_c = i_en && (r_cnt == i_div);

    always_ff @(posedge clk) begin
        if (!rstb)                  r_cnt <= '0;
        else if (!i_en || o_tick_c) r_cnt <= '0;
        else                        r_cnt <= r_cnt + DIV_W'(1);
    end

endmodule

// File: rtl/io_spi_engine.sv
// SPI master with host register interface: CTRL/DATA/DIV/STATUS, per-channel chip select, done irq.
module io_spi_engine
    import io_spi_engine_pkg::*;
#(
    parameter int unsigned N_CS     = 3,
    parameter int unsigned MAX_BITS = 16,
    parameter int unsigned DIV_W    = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             IOWb,
    input  logic             IORb,
    input  logic [1:0]       addr,
    input  logic [BUS_W-1:0] bus_in,
    output logic [BUS_W-1:0] bus_out,
    output logic             bus_oe,
    output logic             sck,
    output logic             sdo,
    input  logic             sdi,
    output logic [N_CS-1:0]  cs_n,
    output logic             irq
);

    localparam logic [3:0] NB_MAX   = 4'(MAX_BITS - 1);
    localparam spi_ctrl_t  CTRL_RST = '{irq_en: 1'b0, ch: 3'd0, lsb_first: 1'b0,
                                        cpha: 1'b0, cpol: 1'b0, nbits_m1: NB_MAX};

    spi_state_e       r_state, w_state_nxt;
    spi_ctrl_t        r_ctrl, w_ctrl_nxt, w_ctrl_wr;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [BUS_W-1:0] r_tx, w_tx_nxt, r_rx_sh, w_rx_sh_nxt, r_rx, w_rx_nxt;
    logic [4:0]       r_bitcnt, w_bitcnt_nxt;
    logic [N_CS-1:0]  r_cs_n, w_cs_n_nxt;
    logic             r_sck, w_sck_nxt, r_sdo, w_sdo_nxt;
    logic             r_done, w_done_nxt, r_ovr, w_ovr_nxt, r_irq;
    logic             r_iowb_q, r_iorb_q;

    logic       w_wr, w_rd_rise, w_busy, w_start, w_tick, w_all_bits, w_last;
    logic       w_lead_entry, w_trail_entry, w_hold_entry, w_end;
    logic [3:0] w_idx, w_idx_nxt;

    io_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk      (clk),
        .rstb     (rstb),
        .i_en     (w_busy),
        .i_div    (r_div),
        .o_tick_c (w_tick)
    );

    assign w_wr       = !IOWb && r_iowb_q;
    assign w_rd_rise  = IORb && !r_iorb_q;
    assign w_busy     = (r_state != ST_IDLE);
    assign w_start    = w_wr && (addr == ADDR_DATA) && !w_busy;
    assign w_all_bits = (r_bitcnt == 5'(r_ctrl.nbits_m1) + 5'd1);
    assign w_last     = (r_bitcnt[3:0] == r_ctrl.nbits_m1);
    assign w_idx      = bit_index(r_ctrl.nbits_m1, r_ctrl.lsb_first, r_bitcnt[3:0]);
    assign w_idx_nxt  = bit_index(r_ctrl.nbits_m1, r_ctrl.lsb_first, r_bitcnt[3:0] + 4'd1);
    assign w_ctrl_wr  = spi_ctrl_t'(bus_in[CTRL_W-1:0]);

    assign w_lead_entry  = w_tick && ((r_state == ST_SETUP) ||
                                      ((r_state == ST_SHIFT_TRAIL) && !w_all_bits));
    assign w_trail_entry = w_tick && (r_state == ST_SHIFT_LEAD);
    assign w_hold_entry  = w_tick && (r_state == ST_SHIFT_TRAIL) && w_all_bits;
    assign w_end         = w_tick && (r_state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (!rstb) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:        if (w_start) w_state_nxt = ST_SETUP;
            ST_SETUP:       if (w_tick)  w_state_nxt = ST_SHIFT_LEAD;
            ST_SHIFT_LEAD:  if (w_tick)  w_state_nxt = ST_SHIFT_TRAIL;
            ST_SHIFT_TRAIL: if (w_tick)  w_state_nxt = w_all_bits ? ST_HOLD : ST_SHIFT_LEAD;
            ST_HOLD:        if (w_tick)  w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // Host register updates first so that a transfer-end done set overrides a same-clk clear
    always_comb begin
        w_ctrl_nxt   = r_ctrl;
        w_div_nxt    = r_div;
        w_tx_nxt     = r_tx;
        w_rx_sh_nxt  = r_rx_sh;
        w_rx_nxt     = r_rx;
        w_bitcnt_nxt = r_bitcnt;
        w_sck_nxt    = r_sck;
        w_sdo_nxt    = r_sdo;
        w_cs_n_nxt   = r_cs_n;
        w_done_nxt   = r_done;
        w_ovr_nxt    = r_ovr;

        if (w_wr) begin
            case (addr)
                ADDR_CTRL: if (!w_busy) begin
                    w_ctrl_nxt = w_ctrl_wr;
                    if (w_ctrl_wr.nbits_m1 > NB_MAX) w_ctrl_nxt.nbits_m1 = NB_MAX;
                end
                ADDR_DATA: if (w_busy) w_ovr_nxt = 1'b1;
                ADDR_DIV:  if (!w_busy) w_div_nxt = DIV_W'(bus_in);
                default: begin
                    if (bus_in[0]) w_done_nxt = 1'b0;
                    if (bus_in[1]) w_ovr_nxt  = 1'b0;
                end
            endcase
        end
        if (w_rd_rise && (addr == ADDR_DATA)) w_done_nxt = 1'b0;

        if (r_state == ST_IDLE) w_sck_nxt = r_ctrl.cpol;

        // Out-of-range channel shifts the one-hot off the top, leaving every cs_n high
        if (w_start) begin
            w_tx_nxt     = bus_in;
            w_rx_sh_nxt  = '0;
            w_bitcnt_nxt = '0;
            w_cs_n_nxt   = ~(N_CS'(1) << r_ctrl.ch);
            if (!r_ctrl.cpha)
                w_sdo_nxt = bus_in[bit_index(r_ctrl.nbits_m1, r_ctrl.lsb_first, 4'd0)];
        end

        if (w_lead_entry) begin
            w_sck_nxt = ~r_sck;
            if (r_ctrl.cpha) w_sdo_nxt = r_tx[w_idx];
            else             w_rx_sh_nxt[w_idx] = sdi;
        end

        if (w_trail_entry) begin
            w_sck_nxt    = ~r_sck;
            w_bitcnt_nxt = r_bitcnt + 5'd1;
            if (r_ctrl.cpha)  w_rx_sh_nxt[w_idx] = sdi;
            else if (!w_last) w_sdo_nxt = r_tx[w_idx_nxt];
        end

        if (w_hold_entry) w_sck_nxt = r_ctrl.cpol;

        if (w_end) begin
            w_cs_n_nxt = '1;
            w_done_nxt = 1'b1;
            w_rx_nxt   = r_rx_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_ctrl   <= CTRL_RST;
            r_div    <= '0;
            r_tx     <= '0;
            r_rx_sh  <= '0;
            r_rx     <= '0;
            r_bitcnt <= '0;
            r_sck    <= 1'b0;
            r_sdo    <= 1'b0;
            r_cs_n   <= '1;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
            r_irq    <= 1'b0;
            r_iowb_q <= 1'b1;
            r_iorb_q <= 1'b1;
        end else begin
            r_ctrl   <= w_ctrl_nxt;
            r_div    <= w_div_nxt;
            r_tx     <= w_tx_nxt;
            r_rx_sh  <= w_rx_sh_nxt;
            r_rx     <= w_rx_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_sck    <= w_sck_nxt;
            r_sdo    <= w_sdo_nxt;
            r_cs_n   <= w_cs_n_nxt;
            r_done   <= w_done_nxt;
            r_ovr    <= w_ovr_nxt;
            r_irq    <= w_done_nxt & w_ctrl_nxt.irq_en;
            r_iowb_q <= IOWb;
            r_iorb_q <= IORb;
        end
    end

    always_comb begin
        case (addr)
            ADDR_CTRL: bus_out = BUS_W'(r_ctrl);
            ADDR_DATA: bus_out = r_rx;
            ADDR_DIV:  bus_out = BUS_W'(r_div);
            default:   bus_out = {13'b0, r_ovr, r_done, w_busy};
        endcase
    end

    assign bus_oe = !IORb;
    assign sck    = r_sck;
    assign sdo    = r_sdo;
    assign cs_n   = r_cs_n;
    assign irq    = r_irq;

endmodule

// File: tb/tb_io_spi_engine.sv
// Directed bench for io_spi_engine: modes, timing, overrun, chip select, irq, held strobe, reset abort.
module tb_io_spi_engine;

    localparam int unsigned N_CS = 3;

    logic            clk = 1'b0;
    logic            rstb, IOWb, IORb;
    logic [1:0]      addr;
    logic [15:0]     bus_in, bus_out;
    logic            bus_oe, sck, sdo, sdi, irq;
    logic [N_CS-1:0] cs_n;

    logic loop_en, sdi_tie, cfg_cpol, cfg_cpha;
    int   checks   = 0;
    int   failures = 0;

    assign sdi = loop_en ? sdo : sdi_tie;

    always #5 clk = ~clk;

    io_spi_engine #(.N_CS(N_CS), .MAX_BITS(16), .DIV_W(8)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .IOWb    (IOWb),
        .IORb    (IORb),
        .addr    (addr),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .bus_oe  (bus_oe),
        .sck     (sck),
        .sdo     (sdo),
        .sdi     (sdi),
        .cs_n    (cs_n),
        .irq     (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; bus_in = d; IOWb = 1'b0;
        @(negedge clk);
        IOWb = 1'b1; addr = 2'd3;
    endtask

    task automatic peek(input logic [1:0] a, output logic [15:0] d);
        addr = a;
        #1;
        d = bus_out;
        addr = 2'd3;
    endtask

    // Start a transfer and watch it until done; returns clks from write edge to done
    task automatic run_xfer(input string tag, input logic [15:0] data, input int ovr_at,
                            output int cyc, output logic [15:0] obs, output int pulses,
                            output int per, output logic [N_CS-1:0] cs_mid);
        logic prev_sck, lead, seen;
        int   first;
        wr(2'd3, 16'h0003);
        wr(2'd1, data);
        obs = '0; pulses = 0; per = 0; first = -1; cyc = -1; seen = 1'b0;
        cs_mid = '1; prev_sck = sck;
        for (int k = 1; k <= 400 && !seen; k++) begin
            @(negedge clk);
            if (sck !== prev_sck) begin
                lead = (sck !== cfg_cpol);
                if (lead) begin
                    pulses++;
                    if (pulses == 1)      first = k;
                    else if (pulses == 2) per = k - first;
                end
                if (lead != cfg_cpha) obs = {obs[14:0], sdo};
            end
            prev_sck = sck;
            if (k == 5) cs_mid = cs_n;
            if (addr == 2'd3 && bus_out[1]) begin
                seen = 1'b1;
                cyc  = k;
            end
            if (k == ovr_at) begin
                addr = 2'd1; bus_in = 16'h5555; IOWb = 1'b0;
            end
            if (ovr_at >= 0 && k == ovr_at + 1) begin
                IOWb = 1'b1; addr = 2'd3;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]     d, obs;
        logic [N_CS-1:0] cs_mid, prev_cs;
        int              cyc, pulses, per, nfall;

        rstb = 1'b0; IOWb = 1'b1; IORb = 1'b1; addr = 2'd3; bus_in = '0;
        loop_en = 1'b1; sdi_tie = 1'b0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cs_n", 32'(cs_n), 32'h7);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_bus_oe", 32'(bus_oe), 32'd0);
        peek(2'd0, d); chk("rst_ctrl", 32'(d), 32'h000F);
        peek(2'd2, d); chk("rst_div", 32'(d), 32'h0);
        peek(2'd1, d); chk("rst_rx", 32'(d), 32'h0);
        peek(2'd3, d); chk("rst_status", 32'(d), 32'h0);
        rstb = 1'b1;

        // Mode 0, 8 bits, DIV 0, loopback
        wr(2'd0, 16'h0007); wr(2'd2, 16'h0000);
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; loop_en = 1'b1;
        run_xfer("m0", 16'h00A5, -1, cyc, obs, pulses, per, cs_mid);
        chk("m0_cycles", 32'(cyc), 32'd18);
        chk("m0_pulses", 32'(pulses), 32'd8);
        chk("m0_sdo_seq", 32'(obs), 32'h00A5);
        chk("m0_cs_mid", 32'(cs_mid), 32'h6);
        peek(2'd1, d); chk("m0_rx", 32'(d), 32'h00A5);
        chk("m0_cs_idle", 32'(cs_n), 32'h7);
        chk("m0_irq_off", 32'(irq), 32'd0);

        // Mode 3, LSB first, 16 bits, DIV 3, sdi tied high
        wr(2'd0, 16'h007F); wr(2'd2, 16'h0003);
        @(negedge clk);
        chk("m3_idle_sck", 32'(sck), 32'd1);
        peek(2'd2, d); chk("m3_div", 32'(d), 32'h3);
        cfg_cpol = 1'b1; cfg_cpha = 1'b1; loop_en = 1'b0; sdi_tie = 1'b1;
        run_xfer("m3", 16'h1234, -1, cyc, obs, pulses, per, cs_mid);
        chk("m3_cycles", 32'(cyc), 32'd136);
        chk("m3_pulses", 32'(pulses), 32'd16);
        chk("m3_period", 32'(per), 32'd8);
        chk("m3_sdo_seq", 32'(obs), 32'h2C48);
        peek(2'd1, d); chk("m3_rx", 32'(d), 32'hFFFF);
        chk("m3_sck_end", 32'(sck), 32'd1);

        // Overrun: second DATA write mid-transfer is discarded
        wr(2'd0, 16'h0007); wr(2'd2, 16'h0000);
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; loop_en = 1'b1;
        run_xfer("ovr", 16'h003C, 3, cyc, obs, pulses, per, cs_mid);
        chk("ovr_cycles", 32'(cyc), 32'd18);
        peek(2'd3, d); chk("ovr_status", 32'(d), 32'h0006);
        peek(2'd1, d); chk("ovr_rx", 32'(d), 32'h003C);
        chk("ovr_sdo_seq", 32'(obs), 32'h003C);
        wr(2'd3, 16'h0002);
        peek(2'd3, d); chk("ovr_cleared", 32'(d), 32'h0002);

        // Channel 2 with irq enabled; rx read clears done/irq on IORb rise
        wr(2'd0, 16'h0507);
        run_xfer("ch2", 16'h0081, -1, cyc, obs, pulses, per, cs_mid);
        chk("ch2_cs_mid", 32'(cs_mid), 32'h3);
        chk("ch2_irq_set", 32'(irq), 32'd1);
        @(negedge clk);
        addr = 2'd1; IORb = 1'b0;
        #1;
        chk("ch2_bus_oe", 32'(bus_oe), 32'd1);
        chk("ch2_rx", 32'(bus_out), 32'h0081);
        @(negedge clk);
        chk("ch2_irq_hold", 32'(irq), 32'd1);
        IORb = 1'b1;
        @(negedge clk);
        chk("ch2_irq_clr", 32'(irq), 32'd0);
        chk("ch2_bus_oe_off", 32'(bus_oe), 32'd0);
        peek(2'd3, d); chk("ch2_status", 32'(d), 32'h0000);

        // DATA strobe held low for 50 clks gives a single transfer
        wr(2'd0, 16'h0007); wr(2'd3, 16'h0003);
        @(negedge clk);
        addr = 2'd1; bus_in = 16'h0055; IOWb = 1'b0;
        prev_cs = cs_n; nfall = 0;
        repeat (50) begin
            @(negedge clk);
            if ((prev_cs & ~cs_n) != '0) nfall++;
            prev_cs = cs_n;
        end
        IOWb = 1'b1; addr = 2'd3;
        repeat (3) @(negedge clk);
        chk("hold_xfers", 32'(nfall), 32'd1);
        peek(2'd3, d); chk("hold_status", 32'(d), 32'h0002);
        peek(2'd1, d); chk("hold_rx", 32'(d), 32'h0055);

        // Reset asserted at clk 5 of a transfer
        wr(2'd3, 16'h0003);
        wr(2'd1, 16'h00C3);
        repeat (4) @(negedge clk);
        chk("rab_cs_active", 32'(cs_n), 32'h6);
        rstb = 1'b0;
        @(negedge clk);
        chk("rab_cs_n", 32'(cs_n), 32'h7);
        chk("rab_sck", 32'(sck), 32'd0);
        peek(2'd3, d); chk("rab_status", 32'(d), 32'h0);
        peek(2'd0, d); chk("rab_ctrl", 32'(d), 32'h000F);
        rstb = 1'b1;
        run_xfer("post", 16'hBEEF, -1, cyc, obs, pulses, per, cs_mid);
        chk("post_cycles", 32'(cyc), 32'd34);
        chk("post_pulses", 32'(pulses), 32'd16);
        chk("post_sdo_seq", 32'(obs), 32'hBEEF);
        peek(2'd1, d); chk("post_rx", 32'(d), 32'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_spi_engine.md
IO_SPI_ENGINE -- requirements
Module: io_spi_engine

Interface
REQ-001 Parameter N_CS, default 3, number of chip-select channels (1..8).
REQ-002 Parameter MAX_BITS, default 16, maximum transfer word length (8..16).
REQ-003 Parameter DIV_W, default 8, clock-divider register width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rstb  in  1  reset, synchronous, active-low.
REQ-006 IOWb  in  1  host write strobe, active-low; one action per low pulse.
REQ-007 IORb  in  1  host read strobe, active-low.
REQ-008 addr  in  2  register select.
REQ-009 bus_in  in  16  host write data.
REQ-010 bus_out  out  16  host read data.
REQ-011 bus_oe  out  1  high while IORb low; drives external tristate.
REQ-012 sck  out  1  shared serial clock.
REQ-013 sdo  out  1  serial data out.
REQ-014 sdi  in  1  serial data in.
REQ-015 cs_n  out  N_CS  per-channel chip select, active-low.
REQ-016 irq  out  1  transfer-complete interrupt, level, active-high.

Function
REQ-017 Write action fires on the first clk where IOWb is low after being high (registered edge detect); held-low IOWb gives exactly one action.
REQ-018 addr 0 write CTRL: [3:0] nbits-1 (clamped to MAX_BITS-1), [4] CPOL, [5] CPHA, [6] lsb_first, [9:7] channel index, [10] irq enable; ignored while busy.
REQ-019 addr 1 write DATA: loads tx shift register and starts transfer if idle; if busy, data discarded, overrun flag set.
REQ-020 addr 2 write DIV: half-period = DIV+1 clk cycles; ignored while busy.
REQ-021 addr 3 write STATUS: bit0=1 clears done, bit1=1 clears overrun.
REQ-022 Reads (combinational on addr): 0 CTRL, 1 rx word right-aligned, 2 DIV zero-extended, 3 {13'b0, overrun, done, busy}.
REQ-023 Read of addr 1 clears done on the clk IORb rises (edge detect).
REQ-024 FSM states IDLE, SETUP, SHIFT_LEAD, SHIFT_TRAIL, HOLD; busy = state != IDLE.
REQ-025 IDLE->SETUP on DATA write: selected cs_n bit low, sck = CPOL; CPHA=0 drives first bit on sdo here.
REQ-026 Each phase lasts DIV+1 clks; SETUP->LEAD->TRAIL->LEAD ... alternates, toggling sck at each phase entry.
REQ-027 CPHA=0: sample sdi on leading edge, shift sdo on trailing edge; CPHA=1: shift on leading, sample on trailing.
REQ-028 After nbits trailing edges -> HOLD (one half-period, sck = CPOL, cs still low) -> IDLE: cs_n all high, done=1, rx latched.
REQ-029 lsb_first=0: MSB of the nbits field first; lsb_first=1: bit 0 first; rx assembled in same order.
REQ-030 Channel index >= N_CS: transfer runs, no cs_n asserts.
REQ-031 irq = done & irq_enable; done set and host clear same clk: set wins.
REQ-032 Total transfer length = (2*nbits+2)*(DIV+1) clks from write-edge clk to done.
REQ-033 sck, sdo stable (registered), never glitch; idle sck = CPOL.

Reset
REQ-034 rstb low at a clk edge: state IDLE, cs_n all 1, sck 0, sdo 0, done 0, overrun 0, irq 0, CTRL 0x000F (16-bit, mode 0, ch 0, irq off), DIV 0, rx 0.
REQ-035 Reset mid-transfer aborts immediately; no done set, cs_n deasserts same edge.

Structure
REQ-036 Shared package holds FSM state enum, register address constants and CTRL field bit positions.
REQ-037 One sub-module io_spi_clkgen (half-period counter, phase-tick output); rest inline.

Verification
REQ-038 Mode 0, 8-bit, DIV=0, DATA=0x00A5, sdi looped to sdo -> 8 sck pulses, sdo 1,0,1,0,0,1,0,1, rx=0x00A5, done at clk 18.
REQ-039 CPOL=1 CPHA=1 lsb_first, 16-bit, DIV=3, DATA=0x1234, sdi tied 1 -> sck idles high, 16 pulses of 8-clk period, sdo LSB-first, rx=0xFFFF, done at clk 136.
REQ-040 DATA write during transfer -> overrun=1, in-flight word unchanged; STATUS write 0x2 -> overrun=0.
REQ-041 Channel 2, irq enable -> only cs_n[2] low during transfer; irq high at end; read addr 1 -> irq low after IORb rises.
REQ-042 IOWb held low 50 clks on DATA -> exactly one transfer.
REQ-043 rstb low at clk 5 of a transfer -> cs_n=all 1, sck=0, done=0 next edge; new transfer after reset completes normally.
